seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 4-digit 7-segment driver: samples a dig_sel/segs scan bus and recovers the displayed BCD digits.
- Filters glitches and debounces per digit. Reports blanked digits, such as the suppressed leading hour digit.
- Flags illegal segment patterns.
- Used as a board-level display monitor and as the self-check end of the clock testbench.

---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/seg7_digit_stab.sv | 78 +++++++
 rtl/seg7_scan_decoder.sv | 164 ++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment-code table for the 4-digit 7-segment scan bus.
// Patterns are active-high gfedcba (bit 0 = segment a).
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] bcd;
    } digit_code_t;

    localparam digit_code_t CODE_BLANK = '{valid: 1'b1, blank: 1'b1, bcd: 4'd0};

    function automatic digit_code_t seg_to_bcd(input logic [6:0] pat);
        digit_code_t code;
        code = '{valid: 1'b1, blank: 1'b0, bcd: 4'd0};
        case (pat)
            SEG_0:     code.bcd = 4'd0;
            SEG_1:     code.bcd = 4'd1;
            SEG_2:     code.bcd = 4'd2;
            SEG_3:     code.bcd = 4'd3;
            SEG_4:     code.bcd = 4'd4;
            SEG_5:     code.bcd = 4'd5;
            SEG_6:     code.bcd = 4'd6;
            SEG_7:     code.bcd = 4'd7;
            SEG_8:     code.bcd = 4'd8;
            SEG_9:     code.bcd = 4'd9;
            SEG_BLANK: code.blank = 1'b1;
            default:   code.valid = 1'b0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_digit_stab.sv
// Per-digit debounce: counts identical consecutive frame values and
// commits the digit once the run reaches STABLE_CNT.
module seg7_digit_stab
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_i,
    input  digit_code_t code_i,
    output logic [3:0]  bcd_o,
    output logic        blank_o
);

    localparam logic [2:0] STAB_MAX = 3'd7;
    localparam logic [2:0] STAB_REQ = 3'(STABLE_CNT);

    logic [2:0] stab_q, stab_d;
    logic       prev_blank_q, prev_blank_d;
    logic [3:0] prev_bcd_q, prev_bcd_d;
    logic       blank_q, blank_d;
    logic [3:0] bcd_q, bcd_d;
    logic       same_s;

    // Stability run update and commit decision for one frame value
    always_comb begin
        stab_d       = stab_q;
        prev_blank_d = prev_blank_q;
        prev_bcd_d   = prev_bcd_q;
        blank_d      = blank_q;
        bcd_d        = bcd_q;
        same_s       = (code_i.blank == prev_blank_q) && (code_i.bcd == prev_bcd_q);
        if (commit_i && code_i.valid) begin
            if (same_s) begin
                if (stab_q != STAB_MAX) begin
                    stab_d = stab_q + 3'd1;
                end else begin
                    stab_d = stab_q;
                end
            end else begin
                stab_d = 3'd1;
            end
            prev_blank_d = code_i.blank;
            prev_bcd_d   = code_i.bcd;
            if (stab_d >= STAB_REQ) begin
                blank_d = code_i.blank;
                bcd_d   = code_i.blank ? 4'd0 : code_i.bcd;
            end else begin
                blank_d = blank_q;
                bcd_d   = bcd_q;
            end
        end else begin
            stab_d = stab_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_q       <= 3'd0;
            prev_blank_q <= 1'b1;
            prev_bcd_q   <= 4'd0;
            blank_q      <= 1'b1;
            bcd_q        <= 4'd0;
        end else begin
            stab_q       <= stab_d;
            prev_blank_q <= prev_blank_d;
            prev_bcd_q   <= prev_bcd_d;
            blank_q      <= blank_d;
            bcd_q        <= bcd_d;
        end
    end

    assign bcd_o   = bcd_q;
    assign blank_o = blank_q;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scan-bus monitor: recovers the digits shown by a multiplexed 7-segment
// driver, filtering short strobes and flagging illegal patterns.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned MIN_STROBE     = 4,
    parameter int unsigned STABLE_CNT     = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic [6:0]              segs,
    output logic [4*NUM_DIGITS-1:0] digit_bcd,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    frame_valid,
    output logic                    seg_err,
    input  logic                    err_clr
);

    localparam int unsigned LEN_W    = $clog2(MIN_STROBE + 1);
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MIN_STROBE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            idx = idx | (v[k] ? IDX_W'(k) : IDX_W'(0));
        end
        return idx;
    endfunction

    logic [NUM_DIGITS-1:0] sel_q, sel_prev_q;
    logic [6:0]            seg_q, seg_prev_q;
    logic [LEN_W-1:0]      strobe_len_q, strobe_len_d;
    digit_code_t           slot_q  [NUM_DIGITS];
    digit_code_t           slot_d  [NUM_DIGITS];
    digit_code_t           frame_q [NUM_DIGITS];
    digit_code_t           frame_d [NUM_DIGITS];
    digit_code_t           merged_s[NUM_DIGITS];
    logic                  frame_end_q, frame_end_d;
    logic                  frame_valid_q;
    logic                  seg_err_q, seg_err_d;

    logic                  run_same_s, run_long_s, prev_onehot_s;
    logic                  capture_s, multi_err_s, cap_err_s, frame_close_s;
    digit_code_t           cap_code_s;
    logic [IDX_W-1:0]      cap_idx_s;

    // Run tracking: a run of one select value that ends after MIN_STROBE cycles is captured
    always_comb begin
        run_same_s    = (sel_q == sel_prev_q) && (sel_q != '0);
        run_long_s    = (strobe_len_q == LEN_MAX);
        prev_onehot_s = is_onehot(sel_prev_q);
        capture_s     = !run_same_s && run_long_s && prev_onehot_s;
        multi_err_s   = run_long_s && !prev_onehot_s;
        cap_code_s    = seg_to_bcd(seg_prev_q);
        cap_idx_s     = onehot_idx(sel_prev_q);
        cap_err_s     = capture_s && !cap_code_s.valid;
        frame_close_s = capture_s && (cap_idx_s == LAST_IDX);
        strobe_len_d  = strobe_len_q;
        if (run_same_s) begin
            if (strobe_len_q != LEN_MAX) begin
                strobe_len_d = strobe_len_q + LEN_W'(1);
            end else begin
                strobe_len_d = strobe_len_q;
            end
        end else if (sel_q != '0) begin
            strobe_len_d = LEN_W'(1);
        end else begin
            strobe_len_d = '0;
        end
    end

    // Frame assembly: merge the capture, then hand the frame over and restart on close
    always_comb begin
        frame_end_d = frame_close_s;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            merged_s[k] = slot_q[k];
            slot_d[k]   = slot_q[k];
            frame_d[k]  = frame_q[k];
            if (capture_s && (cap_idx_s == IDX_W'(k))) begin
                merged_s[k] = cap_code_s;
            end else begin
                merged_s[k] = slot_q[k];
            end
            // Slots never captured in a frame stay at CODE_BLANK, i.e. read as blank
            if (frame_close_s) begin
                frame_d[k] = merged_s[k];
                slot_d[k]  = CODE_BLANK;
            end else begin
                frame_d[k] = frame_q[k];
                slot_d[k]  = merged_s[k];
            end
        end
    end

    // Sticky error: a new error wins over a simultaneous clear
    always_comb begin
        seg_err_d = seg_err_q;
        if (cap_err_s || multi_err_s) begin
            seg_err_d = 1'b1;
        end else if (err_clr) begin
            seg_err_d = 1'b0;
        end else begin
            seg_err_d = seg_err_q;
        end
    end

    // Input sampling, run tracking and frame state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q         <= '0;
            seg_q         <= 7'h00;
            sel_prev_q    <= '0;
            seg_prev_q    <= 7'h00;
            strobe_len_q  <= '0;
            frame_end_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                slot_q[k]  <= CODE_BLANK;
                frame_q[k] <= CODE_BLANK;
            end
        end else begin
            sel_q         <= dig_sel;
            seg_q         <= SEG_ACTIVE_LOW ? ~segs : segs;
            sel_prev_q    <= sel_q;
            seg_prev_q    <= seg_q;
            strobe_len_q  <= strobe_len_d;
            frame_end_q   <= frame_end_d;
            frame_valid_q <= frame_end_q;
            seg_err_q     <= seg_err_d;
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                slot_q[k]  <= slot_d[k];
                frame_q[k] <= frame_d[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        seg7_digit_stab #(
            .STABLE_CNT (STABLE_CNT)
        ) u_stab (
            .clk      (clk),
            .rst      (rst),
            .commit_i (frame_end_q),
            .code_i   (frame_q[g]),
            .bcd_o    (digit_bcd[4*g +: 4]),
            .blank_o  (digit_blank[g])
        );
    end

    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed plus randomized scan-bus stimulus against a frame-level reference model.
module tb_seg7_scan_decoder;

    localparam int N      = 4;
    localparam int MIN    = 4;
    localparam int STABLE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  dig_sel;
    logic [6:0]    segs;
    logic [4*N-1:0] digit_bcd;
    logic [N-1:0]  digit_blank;
    logic          frame_valid;
    logic          seg_err;
    logic          err_clr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: -1 = blank, 0..9 = digit, -3 = illegal, -9 = nothing yet
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int   m_frame [N];
    int   m_prev  [N];
    int   m_stab  [N];
    int   m_shown [N];
    logic m_err;
    int   cur     [N];

    seg7_scan_decoder #(
        .NUM_DIGITS     (N),
        .MIN_STROBE     (MIN),
        .STABLE_CNT     (STABLE),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dig_sel     (dig_sel),
        .segs        (segs),
        .digit_bcd   (digit_bcd),
        .digit_blank (digit_blank),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [6:0] pat);
        if (pat == 7'h00) return -1;
        for (int v = 0; v < 10; v++) begin
            if (seg_tab[v] == pat) return v;
        end
        return -3;
    endfunction

    // Step values: 0..9 digit, -1 not strobed, -2 strobed blank, -4 illegal pattern
    function automatic logic [6:0] pat_of(input int v);
        if (v >= 0) return seg_tab[v];
        if (v == -4) return 7'h49;
        return 7'h00;
    endfunction

    function automatic logic [15:0] exp_bcd();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (m_shown[i] >= 0) r[4*i +: 4] = 4'(m_shown[i]);
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_blank();
        logic [3:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_shown[i] < 0);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_frame[i] = -1;
            m_prev[i]  = -9;
            m_stab[i]  = 0;
            m_shown[i] = -1;
        end
        m_err = 1'b0;
    endtask

    task automatic model_commit();
        for (int i = 0; i < N; i++) begin
            if (m_frame[i] != -3) begin
                if (m_frame[i] == m_prev[i]) m_stab[i] = (m_stab[i] < 7) ? m_stab[i] + 1 : 7;
                else m_stab[i] = 1;
                m_prev[i] = m_frame[i];
                if (m_stab[i] >= STABLE) m_shown[i] = m_frame[i];
            end
            m_frame[i] = -1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_bcd"},   32'(digit_bcd),   32'(exp_bcd()));
        check({tag, "_blank"}, 32'(digit_blank), 32'(exp_blank()));
        check({tag, "_err"},   32'(seg_err),     32'(m_err));
    endtask

    task automatic close_frame();
        dig_sel = '0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("frame_valid_latency", 32'(frame_valid), 32'(k == 3));
        end
        model_commit();
        check_outputs("commit");
        tick();
        check("frame_valid_pulse", 32'(frame_valid), 32'd0);
    endtask

    task automatic strobe(input int idx, input logic [6:0] pat, input int len);
        dig_sel      = '0;
        dig_sel[idx] = 1'b1;
        segs         = ~pat;
        repeat (len) tick();
        if (len >= MIN) begin
            m_frame[idx] = ref_decode(pat);
            if (m_frame[idx] == -3) m_err = 1'b1;
            if (idx == N - 1) close_frame();
        end
    endtask

    task automatic glitch(input int idx, input logic [6:0] pat, input int len);
        dig_sel = '0;
        tick();
        strobe(idx, pat, len);
        dig_sel = '0;
        tick();
    endtask

    task automatic frame4(input int a, input int b, input int c, input int d, input int len);
        if (a != -1) strobe(0, pat_of(a), len);
        if (b != -1) strobe(1, pat_of(b), len);
        if (c != -1) strobe(2, pat_of(c), len);
        strobe(3, pat_of(d), len);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err   = 1'b0;
        check("err_clr", 32'(seg_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; dig_sel = '0; segs = 7'h7F; err_clr = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        check_outputs("reset");
        check("reset_fv", 32'(frame_valid), 32'd0);

        // "1234" twice: committed on the second frame
        frame4(1, 2, 3, 4, 8);
        frame4(1, 2, 3, 4, 8);
        check("ideal_1234", 32'(digit_bcd), 32'h4321);

        // Leading digit never strobed
        frame4(-1, 9, 4, 5, 8);
        frame4(-1, 9, 4, 5, 8);
        check("blank_lead", 32'(digit_blank), 32'h1);

        frame4(1, 2, 3, 4, 8);
        frame4(1, 2, 3, 4, 8);
        // Short strobe of an 8 on digit 2 must be ignored
        strobe(0, pat_of(1), 8);
        strobe(1, pat_of(2), 8);
        glitch(2, pat_of(8), 2);
        strobe(2, pat_of(3), 8);
        strobe(3, pat_of(4), 8);
        check("glitch_ignored", 32'(digit_bcd), 32'h4321);

        // Illegal pattern on digit 3
        frame4(1, 2, 3, -4, 6);
        check("illegal_err", 32'(seg_err), 32'd1);
        clear_err();

        // Alternating digit 3 never commits, then a stable 6 does
        frame4(1, 2, 3, 5, 5);
        frame4(1, 2, 3, 6, 5);
        frame4(1, 2, 3, 5, 5);
        check("alternate_hold", 32'(digit_bcd[15:12]), 32'd4);
        frame4(1, 2, 3, 6, 5);
        frame4(1, 2, 3, 6, 5);
        check("stable_six", 32'(digit_bcd[15:12]), 32'd6);

        // Multi-hot select: short is harmless, long sets the error
        dig_sel = 4'b0101; segs = ~seg_tab[8];
        repeat (2) tick();
        dig_sel = '0;
        repeat (3) tick();
        check("multihot_short", 32'(seg_err), 32'd0);
        dig_sel = 4'b0101;
        repeat (6) tick();
        dig_sel = '0;
        m_err = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("multihot_no_frame", 32'(frame_valid), 32'd0);
        end
        check_outputs("multihot");
        clear_err();

        // Idle bus: nothing moves
        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle_no_frame", 32'(frame_valid), 32'd0);
        end
        check_outputs("idle");

        // Reset in the middle of a frame
        strobe(0, pat_of(1), 8);
        dig_sel = 4'b0010; segs = ~seg_tab[2];
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dig_sel = '0;
        model_reset();
        check_outputs("midframe_reset");
        repeat (3) tick();
        frame4(1, 2, 3, 4, 8);
        check("after_reset_f1", 32'(digit_blank), 32'hF);
        frame4(1, 2, 3, 4, 8);
        check("after_reset_f2", 32'(digit_bcd), 32'h4321);

        // Randomized frames
        for (int d = 0; d < N; d++) cur[d] = d + 1;
        for (int f = 0; f < 40; f++) begin
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 9) >= 7) begin
                    int r;
                    r = int'($urandom_range(0, 13));
                    if (r <= 9)       cur[d] = r;
                    else if (r == 10) cur[d] = -2;
                    else if (r == 11) cur[d] = (d < N - 1) ? -1 : -2;
                    else if (r == 12) cur[d] = -4;
                    else              cur[d] = int'($urandom_range(0, 9));
                end
            end
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(0, 4) == 0)
                    glitch(int'($urandom_range(0, N - 1)), 7'($urandom_range(0, 127)),
                           int'($urandom_range(1, MIN - 1)));
                if (cur[d] != -1)
                    strobe(d, pat_of(cur[d]), int'($urandom_range(MIN, MIN + 4)));
            end
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
